// File: rtl/fetch_redirect_controller_if.sv
// Fetch-side control bundle: redirect requests and hazard information flow
// from the pipeline into the controller; the fetch PC, validity, stall/flush
// controls and performance counters flow back out.
interface fetch_redirect_controller_if;
  // Fetch prediction and redirect requests
  logic [31:0] predict_pc;
  logic        jalr;
  logic [31:0] stage_e_pc;
  logic        mispredict;
  logic [31:0] stage_m_pc;
  logic        ret;
  logic [31:0] stage_w_pc;

  // Load-use hazard inputs
  logic        d_valid;
  logic [4:0]  register_number_a;
  logic [4:0]  register_number_b;
  logic        e_load;
  logic [4:0]  e_destination_register_number;

  // Controller outputs
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        stall_fd;
  logic        flush_d;
  logic        flush_e;
  logic        flush_m;
  logic [31:0] redirect_count;
  logic [31:0] stall_count;
  logic [1:0]  ctrl_state;

  // Pipeline side: supplies requests, consumes controls
  modport master (
    output predict_pc, jalr, stage_e_pc, mispredict, stage_m_pc, ret, stage_w_pc,
    output d_valid, register_number_a, register_number_b, e_load,
    output e_destination_register_number,
    input  fetch_pc, fetch_valid, stall_fd, flush_d, flush_e, flush_m,
    input  redirect_count, stall_count, ctrl_state
  );

  // Controller side
  modport slave (
    input  predict_pc, jalr, stage_e_pc, mispredict, stage_m_pc, ret, stage_w_pc,
    input  d_valid, register_number_a, register_number_b, e_load,
    input  e_destination_register_number,
    output fetch_pc, fetch_valid, stall_fd, flush_d, flush_e, flush_m,
    output redirect_count, stall_count, ctrl_state
  );
endinterface

// File: rtl/fetch_redirect_controller.sv
// Fetch redirect controller: selects the next fetch PC between the predicted
// PC and redirects from E (jalr), M (mispredict) and W (ret), inserts a
// one-cycle load-use bubble, raises per-stage flushes and holds fetch_valid
// low while the instruction memory refills after a redirect or reset.
// Every output is registered.
module fetch_redirect_controller #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned REFILL_CYCLES = 1  // legal range 1..15
) (
  input  logic                             clk,
  input  logic                             reset,  // async, active-low
  fetch_redirect_controller_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  localparam logic [3:0] REFILL_INIT = 4'(REFILL_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  refill_q, refill_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        stall_q, stall_d;
  logic        flush_d_q, flush_d_d;
  logic        flush_e_q, flush_e_d;
  logic        flush_m_q, flush_m_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        load_use;

  // Redirect arbitration (oldest stage wins) and load-use hazard detection
  always_comb begin
    redirect        = bus.ret | bus.mispredict | bus.jalr;
    redirect_target = bus.ret        ? bus.stage_w_pc :
                      bus.mispredict ? bus.stage_m_pc :
                                       bus.stage_e_pc;
    load_use = bus.e_load && bus.d_valid &&
               (bus.e_destination_register_number != 5'd0) &&
               ((bus.e_destination_register_number == bus.register_number_a) ||
                (bus.e_destination_register_number == bus.register_number_b));
  end

  // Next-state and next-output decision
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    refill_d       = refill_q;
    pc_d           = pc_q;
    valid_d        = valid_q;
    stall_d        = 1'b0;
    flush_d_d      = 1'b0;
    flush_e_d      = 1'b0;
    flush_m_d      = 1'b0;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;

    if (redirect) begin
      // A redirect overrides everything, whatever state we are in.
      state_d        = ST_REFILL;
      refill_d       = REFILL_INIT;
      pc_d           = redirect_target;
      valid_d        = 1'b0;
      flush_d_d      = 1'b1;
      flush_e_d      = bus.ret | bus.mispredict;
      flush_m_d      = bus.ret;
      redirect_cnt_d = (redirect_cnt_q == '1) ? redirect_cnt_q
                                              : redirect_cnt_q + 32'd1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          valid_d = 1'b1;
          if (load_use) begin
            // Hold F/D and send a bubble into E; PC stays put.
            stall_d     = 1'b1;
            flush_e_d   = 1'b1;
            stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q
                                              : stall_cnt_q + 32'd1;
            state_d     = ST_HOLD;
          end else begin
            pc_d = bus.predict_pc;
          end
        end
        ST_HOLD: begin
          // The bubble resolves the hazard; no re-check here.
          pc_d    = bus.predict_pc;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end
        ST_REFILL: begin
          if (refill_q <= 4'd1) begin
            // Last refill cycle: issue the target instruction itself.
            valid_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            valid_d  = 1'b0;
            refill_d = refill_q - 4'd1;
          end
        end
        default: begin
          state_d  = ST_REFILL;
          refill_d = REFILL_INIT;
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_REFILL;
      refill_q       <= REFILL_INIT;
      pc_q           <= RESET_PC;
      valid_q        <= 1'b0;
      stall_q        <= 1'b0;
      flush_d_q      <= 1'b0;
      flush_e_q      <= 1'b0;
      flush_m_q      <= 1'b0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q        <= state_d;
      refill_q       <= refill_d;
      pc_q           <= pc_d;
      valid_q        <= valid_d;
      stall_q        <= stall_d;
      flush_d_q      <= flush_d_d;
      flush_e_q      <= flush_e_d;
      flush_m_q      <= flush_m_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign bus.fetch_pc       = pc_q;
  assign bus.fetch_valid    = valid_q;
  assign bus.stall_fd       = stall_q;
  assign bus.flush_d        = flush_d_q;
  assign bus.flush_e        = flush_e_q;
  assign bus.flush_m        = flush_m_q;
  assign bus.redirect_count = redirect_cnt_q;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.ctrl_state     = state_q;

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Testbench for fetch_redirect_controller. Two instances share one stimulus
// stream: one with REFILL_CYCLES=1 and RESET_PC=0, one with REFILL_CYCLES=3
// and RESET_PC=0x1000. A reference model tracks each instance's PC, refill
// cycles left, pending bubble and counters from the behavioural rules.
module tb_fetch_redirect_controller;

  localparam int NI = 2;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'h0000_1000;
  localparam int REFILL0 = 1;
  localparam int REFILL1 = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        stall;
    logic        fd;
    logic        fe;
    logic        fm;
    logic [31:0] rc;
    logic [31:0] sc;
    logic [1:0]  st;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [31:0] s_predict_pc = '0;
  logic        s_jalr = 0, s_misp = 0, s_ret = 0;
  logic [31:0] s_e_pc = '0, s_m_pc = '0, s_w_pc = '0;
  logic        s_d_valid = 0, s_e_load = 0;
  logic [4:0]  s_ra = '0, s_rb = '0, s_e_dest = '0;

  int checks = 0;
  int errors = 0;

  fetch_redirect_controller_if if0();
  fetch_redirect_controller_if if1();

  assign if0.predict_pc = s_predict_pc;
  assign if0.jalr = s_jalr;
  assign if0.stage_e_pc = s_e_pc;
  assign if0.mispredict = s_misp;
  assign if0.stage_m_pc = s_m_pc;
  assign if0.ret = s_ret;
  assign if0.stage_w_pc = s_w_pc;
  assign if0.d_valid = s_d_valid;
  assign if0.register_number_a = s_ra;
  assign if0.register_number_b = s_rb;
  assign if0.e_load = s_e_load;
  assign if0.e_destination_register_number = s_e_dest;

  assign if1.predict_pc = s_predict_pc;
  assign if1.jalr = s_jalr;
  assign if1.stage_e_pc = s_e_pc;
  assign if1.mispredict = s_misp;
  assign if1.stage_m_pc = s_m_pc;
  assign if1.ret = s_ret;
  assign if1.stage_w_pc = s_w_pc;
  assign if1.d_valid = s_d_valid;
  assign if1.register_number_a = s_ra;
  assign if1.register_number_b = s_rb;
  assign if1.e_load = s_e_load;
  assign if1.e_destination_register_number = s_e_dest;

  fetch_redirect_controller #(.RESET_PC(RPC0), .REFILL_CYCLES(REFILL0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  fetch_redirect_controller #(.RESET_PC(RPC1), .REFILL_CYCLES(REFILL1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  obs_t obs [NI];
  assign obs[0] = {if0.fetch_pc, if0.fetch_valid, if0.stall_fd, if0.flush_d,
                   if0.flush_e, if0.flush_m, if0.redirect_count,
                   if0.stall_count, if0.ctrl_state};
  assign obs[1] = {if1.fetch_pc, if1.fetch_valid, if1.stall_fd, if1.flush_d,
                   if1.flush_e, if1.flush_m, if1.redirect_count,
                   if1.stall_count, if1.ctrl_state};

  // ---------------- reference model ----------------
  int          m_refill   [NI] = '{REFILL0, REFILL1};
  logic [31:0] m_reset_pc [NI] = '{RPC0, RPC1};
  logic [31:0] m_pc [NI];
  int          m_left [NI];   // invalid fetch cycles still to come
  bit          m_bub [NI];    // a stall bubble is in progress
  bit          m_valid [NI], m_stall [NI], m_fd [NI], m_fe [NI], m_fm [NI];
  logic [31:0] m_rc [NI], m_sc [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_pc[k] = m_reset_pc[k];
      m_left[k] = m_refill[k];
      m_bub[k] = 0;
      m_valid[k] = 0; m_stall[k] = 0;
      m_fd[k] = 0; m_fe[k] = 0; m_fm[k] = 0;
      m_rc[k] = 0; m_sc[k] = 0;
    end
  endtask

  task automatic model_step();
    bit redir, hz;
    logic [31:0] tgt;
    redir = s_ret || s_misp || s_jalr;
    tgt = s_ret ? s_w_pc : (s_misp ? s_m_pc : s_e_pc);
    hz = s_e_load && s_d_valid && (s_e_dest != 0) &&
         ((s_e_dest == s_ra) || (s_e_dest == s_rb));
    for (int k = 0; k < NI; k++) begin
      m_stall[k] = 0; m_fd[k] = 0; m_fe[k] = 0; m_fm[k] = 0;
      if (redir) begin
        m_pc[k] = tgt;
        m_left[k] = m_refill[k];
        m_bub[k] = 0;
        m_valid[k] = 0;
        m_fd[k] = 1;
        if (s_ret) begin m_fe[k] = 1; m_fm[k] = 1; end
        else if (s_misp) m_fe[k] = 1;
        if (m_rc[k] != 32'hFFFF_FFFF) m_rc[k] = m_rc[k] + 1;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
        m_valid[k] = (m_left[k] == 0);
      end else if (m_bub[k]) begin
        m_bub[k] = 0;
        m_pc[k] = s_predict_pc;
        m_valid[k] = 1;
      end else if (hz) begin
        m_bub[k] = 1;
        m_stall[k] = 1;
        m_fe[k] = 1;
        m_valid[k] = 1;
        if (m_sc[k] != 32'hFFFF_FFFF) m_sc[k] = m_sc[k] + 1;
      end else begin
        m_pc[k] = s_predict_pc;
        m_valid[k] = 1;
      end
    end
  endtask

  function automatic obs_t model_obs(int k);
    obs_t o;
    o.pc = m_pc[k];
    o.valid = m_valid[k];
    o.stall = m_stall[k];
    o.fd = m_fd[k];
    o.fe = m_fe[k];
    o.fm = m_fm[k];
    o.rc = m_rc[k];
    o.sc = m_sc[k];
    o.st = (m_left[k] > 0) ? 2'd2 : (m_bub[k] ? 2'd1 : 2'd0);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pc=%h v=%b stall=%b flush=%b%b%b rc=%0d sc=%0d st=%0d",
                     o.pc, o.valid, o.stall, o.fd, o.fe, o.fm, o.rc, o.sc, o.st);
  endfunction

  // One clock: model updates with the inputs present at the edge, outputs
  // are then sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    s_jalr = 0; s_misp = 0; s_ret = 0;
    s_d_valid = 0; s_e_load = 0;
    s_ra = 0; s_rb = 0; s_e_dest = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    s_predict_pc = 32'h4;
    apply_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs[k] !== model_obs(k)) begin
        errors++;
        $display("FAIL reset_state[%0d] got %s want %s", k, fmt(obs[k]), fmt(model_obs(k)));
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      s_predict_pc = m_pc[0] + 32'd4;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs[k] !== model_obs(k)) begin
          errors++;
          $display("FAIL reset_release[%0d] cyc%0d got %s want %s", k, c, fmt(obs[k]), fmt(model_obs(k)));
        end
      end
    end
    checks++;
    if (if0.fetch_pc !== 32'h8 || if0.fetch_valid !== 1'b1 || if0.ctrl_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_seq got pc=%h v=%b st=%0d want pc=00000008 v=1 st=0",
               if0.fetch_pc, if0.fetch_valid, if0.ctrl_state);
    end
  endtask

  task automatic test_priority();
    s_e_pc = 32'h100; s_m_pc = 32'h200; s_w_pc = 32'h300;
    s_jalr = 1; s_misp = 1; s_ret = 1;
    tick();
    clear_inputs();
    checks++;
    if (if0.fetch_pc !== 32'h300 || {if0.flush_d, if0.flush_e, if0.flush_m} !== 3'b111 ||
        if0.redirect_count !== 32'd1 || if0.ctrl_state !== 2'd2 || if0.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL priority got pc=%h flush=%b%b%b rc=%0d st=%0d v=%b want pc=00000300 flush=111 rc=1 st=2 v=0",
               if0.fetch_pc, if0.flush_d, if0.flush_e, if0.flush_m, if0.redirect_count,
               if0.ctrl_state, if0.fetch_valid);
    end
    tick();
    checks++;
    if (if0.fetch_valid !== 1'b1 || if0.fetch_pc !== 32'h300) begin
      errors++;
      $display("FAIL priority_refill got v=%b pc=%h want v=1 pc=00000300", if0.fetch_valid, if0.fetch_pc);
    end
    // Each source alone, with its flush pattern, then let refill finish
    for (int src = 0; src < 3; src++) begin
      s_jalr = (src == 0); s_misp = (src == 1); s_ret = (src == 2);
      s_e_pc = 32'h1000 + src; s_m_pc = 32'h2000 + src; s_w_pc = 32'h3000 + src;
      for (int c = 0; c < 5; c++) begin
        tick();
        clear_inputs();
        s_predict_pc = m_pc[0] + 32'd4;
        for (int k = 0; k < NI; k++) begin
          checks++;
          if (obs[k] !== model_obs(k)) begin
            errors++;
            $display("FAIL single_src%0d[%0d] cyc%0d got %s want %s", src, k, c, fmt(obs[k]), fmt(model_obs(k)));
          end
        end
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] sc_before;
    s_misp = 1; s_m_pc = 32'h40; s_predict_pc = 32'h40;
    for (int c = 0; c < 5; c++) begin
      tick();
      clear_inputs();
    end
    sc_before = m_sc[0];
    s_predict_pc = 32'h44;
    s_e_load = 1; s_e_dest = 5; s_ra = 5; s_rb = 9; s_d_valid = 1;
    tick();
    checks++;
    if (if0.stall_fd !== 1'b1 || if0.flush_e !== 1'b1 || if0.fetch_pc !== 32'h40 ||
        if0.fetch_valid !== 1'b1 || if0.stall_count !== sc_before + 32'd1 || if0.ctrl_state !== 2'd1) begin
      errors++;
      $display("FAIL load_use got stall=%b fe=%b pc=%h v=%b sc=%0d st=%0d want stall=1 fe=1 pc=00000040 v=1 sc=%0d st=1",
               if0.stall_fd, if0.flush_e, if0.fetch_pc, if0.fetch_valid, if0.stall_count,
               if0.ctrl_state, sc_before + 32'd1);
    end
    // Hazard inputs still present during HOLD: must not stall again
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs[k] !== model_obs(k)) begin
        errors++;
        $display("FAIL load_use_hold[%0d] got %s want %s", k, fmt(obs[k]), fmt(model_obs(k)));
      end
    end
    checks++;
    if (if0.fetch_pc !== 32'h44 || if0.stall_fd !== 1'b0 || if0.flush_e !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release got pc=%h stall=%b fe=%b want pc=00000044 stall=0 fe=0",
               if0.fetch_pc, if0.stall_fd, if0.flush_e);
    end
    // Destination x0 never stalls
    s_predict_pc = 32'h48; s_e_dest = 0; s_ra = 0; s_rb = 0;
    tick();
    checks++;
    if (if0.stall_fd !== 1'b0 || if0.fetch_pc !== 32'h48 || if0.stall_count !== sc_before + 32'd1) begin
      errors++;
      $display("FAIL load_use_x0 got stall=%b pc=%h sc=%0d want stall=0 pc=00000048 sc=%0d",
               if0.stall_fd, if0.fetch_pc, if0.stall_count, sc_before + 32'd1);
    end
    clear_inputs();
  endtask

  task automatic test_hazard_redirect();
    logic [31:0] sc_before;
    sc_before = m_sc[0];
    s_e_load = 1; s_e_dest = 7; s_rb = 7; s_ra = 3; s_d_valid = 1;
    s_misp = 1; s_m_pc = 32'h80;
    tick();
    clear_inputs();
    checks++;
    if (if0.fetch_pc !== 32'h80 || if0.stall_fd !== 1'b0 ||
        {if0.flush_d, if0.flush_e, if0.flush_m} !== 3'b110 || if0.stall_count !== sc_before) begin
      errors++;
      $display("FAIL hazard_redirect got pc=%h stall=%b flush=%b%b%b sc=%0d want pc=00000080 stall=0 flush=110 sc=%0d",
               if0.fetch_pc, if0.stall_fd, if0.flush_d, if0.flush_e, if0.flush_m,
               if0.stall_count, sc_before);
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs[k] !== model_obs(k)) begin
        errors++;
        $display("FAIL hazard_redirect_model[%0d] got %s want %s", k, fmt(obs[k]), fmt(model_obs(k)));
      end
    end
  endtask

  task automatic test_refill_restart();
    clear_inputs();
    s_predict_pc = 32'h4;
    apply_reset();
    for (int c = 0; c < 4; c++) tick();
    s_jalr = 1; s_e_pc = 32'h20;
    tick();
    clear_inputs();
    tick();
    s_misp = 1; s_m_pc = 32'h60;
    tick();
    clear_inputs();
    checks++;
    if (if1.fetch_pc !== 32'h60 || if1.redirect_count !== 32'd2 || if1.fetch_valid !== 1'b0 ||
        if1.ctrl_state !== 2'd2) begin
      errors++;
      $display("FAIL refill_restart got pc=%h rc=%0d v=%b st=%0d want pc=00000060 rc=2 v=0 st=2",
               if1.fetch_pc, if1.redirect_count, if1.fetch_valid, if1.ctrl_state);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (if1.fetch_valid !== (c == 2) || if1.fetch_pc !== 32'h60) begin
        errors++;
        $display("FAIL refill_wait cyc%0d got v=%b pc=%h want v=%b pc=00000060",
                 c, if1.fetch_valid, if1.fetch_pc, (c == 2));
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs[k] !== model_obs(k)) begin
          errors++;
          $display("FAIL refill_model[%0d] cyc%0d got %s want %s", k, c, fmt(obs[k]), fmt(model_obs(k)));
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    s_predict_pc = 32'h64;
    s_e_load = 1; s_e_dest = 12; s_ra = 12; s_d_valid = 1;
    tick();
    clear_inputs();
    checks++;
    if (if0.ctrl_state !== 2'd1 || if1.ctrl_state !== 2'd1) begin
      errors++;
      $display("FAIL hold_entry got st0=%0d st1=%0d want 1 1", if0.ctrl_state, if1.ctrl_state);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (if0.fetch_pc !== RPC0 || if1.fetch_pc !== RPC1 || if0.fetch_valid !== 1'b0 ||
        if0.stall_fd !== 1'b0 || {if0.flush_d, if0.flush_e, if0.flush_m} !== 3'b000 ||
        if0.redirect_count !== 32'd0 || if0.stall_count !== 32'd0 ||
        if1.stall_count !== 32'd0 || if0.ctrl_state !== 2'd2) begin
      errors++;
      $display("FAIL async_reset got pc0=%h pc1=%h v=%b stall=%b flush=%b%b%b rc=%0d sc0=%0d sc1=%0d st=%0d want pc0=%h pc1=%h v=0 stall=0 flush=000 rc=0 sc=0 st=2",
               if0.fetch_pc, if1.fetch_pc, if0.fetch_valid, if0.stall_fd, if0.flush_d,
               if0.flush_e, if0.flush_m, if0.redirect_count, if0.stall_count,
               if1.stall_count, if0.ctrl_state, RPC0, RPC1);
    end
    model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs[k] !== model_obs(k)) begin
        errors++;
        $display("FAIL async_reset_model[%0d] got %s want %s", k, fmt(obs[k]), fmt(model_obs(k)));
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s_predict_pc = (($urandom_range(0, 3) == 0) ? $urandom : m_pc[0] + 32'd4);
      s_jalr = ($urandom_range(0, 9) == 0);
      s_misp = ($urandom_range(0, 9) == 0);
      s_ret  = ($urandom_range(0, 11) == 0);
      s_e_pc = $urandom; s_m_pc = $urandom; s_w_pc = $urandom;
      s_d_valid = ($urandom_range(0, 3) != 0);
      s_e_load  = ($urandom_range(0, 2) == 0);
      s_ra = 5'($urandom_range(0, 3));
      s_rb = 5'($urandom_range(0, 3));
      s_e_dest = 5'($urandom_range(0, 3));
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs[k] !== model_obs(k)) begin
          errors++;
          $display("FAIL random[%0d] cyc%0d got %s want %s", k, c, fmt(obs[k]), fmt(model_obs(k)));
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_hazard_redirect();
    test_refill_restart();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after 2ms, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_redirect_controller.md
Name: fetch_redirect_controller

Overview:
- Sequences the program counter driven into the fetch/decode stage.
- Arbitrates between three redirect sources: jalr resolved in E, mispredict resolved in M, ret resolved in W. Otherwise it follows the predicted PC.
- Inserts load-use stall bubbles, generates per-stage flush signals, and gates fetch validity while the instruction memory refills after a redirect.
- Maintains saturating performance counters for redirects and stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- REFILL_CYCLES, 1, cycles fetch_valid is held low after a redirect or reset (range 1..15).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- predict_pc  in  32  next PC proposed by the fetch stage (pc+4 or jal target).
- jalr  in  1  E-stage jalr redirect request.
- stage_e_pc  in  32  jalr target.
- mispredict  in  1  M-stage branch mispredict request.
- stage_m_pc  in  32  corrected branch target.
- ret  in  1  W-stage ret redirect request.
- stage_w_pc  in  32  return target.
- d_valid  in  1  decode stage holds a valid instruction.
- register_number_a  in  5  decode rs1.
- register_number_b  in  5  decode rs2.
- e_load  in  1  E stage holds a load.
- e_destination_register_number  in  5  load destination.
- fetch_pc  out  32  registered PC presented to instruction memory.
- fetch_valid  out  1  fetch_pc instruction is on the correct path and may enter decode.
- stall_fd  out  1  hold the F/D pipeline registers this cycle.
- flush_d  out  1  squash the decode-stage instruction.
- flush_e  out  1  squash, or inject a bubble into, the E stage.
- flush_m  out  1  squash the M-stage instruction.
- redirect_count  out  32  number of accepted redirects.
- stall_count  out  32  number of load-use stall cycles.
- ctrl_state  out  2  current FSM state: 0 RUN, 1 HOLD, 2 REFILL.

Behaviour:
- All outputs are registered. A decision made from inputs sampled at posedge N appears on outputs after posedge N.
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; state=REFILL with refill counter=REFILL_CYCLES.
  - fetch_valid, stall_fd, flush_d/e/m = 0.
  - Both counters = 0.
  - Reset asserted mid-redirect or mid-stall discards all pending activity.
- Redirect priority, oldest stage wins: ret > mispredict > jalr. Lower-priority requests in the same cycle are dropped, not queued.
- On an accepted redirect, from any state:
  - fetch_pc <= selected target; state <= REFILL; counter <= REFILL_CYCLES; redirect_count += 1.
  - ret: flush_d=flush_e=flush_m=1.
  - mispredict: flush_d=flush_e=1, flush_m=0.
  - jalr: flush_d=1, flush_e=flush_m=0.
  - stall_fd=0; fetch_valid=0.
- Load-use hazard = e_load & d_valid & (e_destination_register_number != 0) & (e_destination_register_number == register_number_a or e_destination_register_number == register_number_b).
- RUN:
  - Redirect takes precedence over a hazard.
  - Else if hazard: fetch_pc held; stall_fd=1; flush_e=1 (bubble); fetch_valid stays 1; stall_count += 1; state <= HOLD.
  - Else: fetch_pc <= predict_pc; fetch_valid=1; all flush and stall outputs 0.
- HOLD:
  - Lasts exactly one cycle. Next cycle: redirect if requested, else fetch_pc <= predict_pc, stall_fd=0, flush_e=0, state <= RUN.
  - The hazard is not re-evaluated in HOLD; the bubble resolves it.
- REFILL:
  - fetch_valid=0; fetch_pc held; flushes 0 after the first cycle.
  - Counter decrements each cycle. When it reaches 1, the next state is RUN with fetch_valid=1 and fetch_pc unchanged, so the target instruction is issued.
  - A new redirect during REFILL restarts REFILL with the new target.
  - Hazards are ignored in REFILL.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Targets pass through unmodified. Alignment is not checked.

Test Plan:
- Reset release, REFILL_CYCLES=1, predict_pc=pc+4: fetch_pc=0, fetch_valid=0 for 1 cycle, then 0→4→8 with fetch_valid=1 and ctrl_state=0.
- Same-cycle jalr (0x100), mispredict (0x200), ret (0x300): fetch_pc=0x300; flush_d/e/m=1,1,1; redirect_count=1; ctrl_state=2; fetch_valid=0 one cycle.
- Load-use: e_load=1, e_dest=5, rs_a=5, d_valid=1 at pc 0x40: stall_fd=1, flush_e=1, fetch_pc stays 0x40 for one cycle, stall_count=1, then advances to predict_pc. Repeating the test with e_dest=0 produces no stall.
- Hazard plus mispredict (0x80) in the same cycle: redirect wins; stall_fd=0; flush_d=flush_e=1; stall_count unchanged; fetch_pc=0x80.
- REFILL_CYCLES=3, jalr to 0x20, then mispredict to 0x60 during the second refill cycle: fetch_pc=0x60; fetch_valid stays 0 for 3 more cycles; redirect_count=2.
- reset driven low mid-HOLD: all outputs return to reset values immediately, without waiting for a clock edge; counters=0; fetch_pc=RESET_PC.
